// File: rtl/tensor_pkg.sv
// Shared types for the tensor datapath: reader FSM encoding and stream buffer depth.
// No logic; imported by the reader and its stream buffer.
package tensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam int STREAM_BUF_DEPTH = 2;

endpackage

// File: rtl/tensor_ram_reader_if.sv
// Valid/ready word stream from the tensor RAM reader to the compute stage.
// Transfer happens on a rising edge where m_valid & m_ready.
interface tensor_ram_reader_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/stream_skid_fifo.sv
// Small stream FIFO: head visible combinationally, 1-cycle push-to-head latency.
// Pop on empty and push on full (without a same-cycle pop) are ignored.
module stream_skid_fifo
  import tensor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = STREAM_BUF_DEPTH,
  parameter int CNT_W      = $clog2(DEPTH + 1),
  parameter int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_vld_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  output logic [CNT_W-1:0]      count_o,
  output logic [DATA_WIDTH-1:0] head_dat_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  assign do_pop     = pop_i && (count_q != '0);
  assign do_push    = push_vld_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/tensor_ram_reader.sv
// Walks LEN words of the tensor RAM from BASE onto a valid/ready stream; first word 2 edges after start,
// 1 word/cycle when unstalled; a 2-entry buffer absorbs read latency under stalls. READER_STRIDE_EN enables a stride step.
module tensor_ram_reader
  import tensor_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  tensor_ram_reader_if.master   m_if,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(STREAM_BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] step_q, step_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  issue, pop;
  logic [CNT_W-1:0]      buf_count;
  logic [OCC_W-1:0]      occupancy;

  assign pop         = m_if.m_valid & m_if.m_ready;
  assign m_if.m_valid = (buf_count != '0);
  assign ram_addr    = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  // Slots already committed (buffered + in flight) after this cycle's pop.
  assign occupancy = OCC_W'(buf_count) + OCC_W'(inflight_q) - OCC_W'(pop);

  `ifndef READER_STRIDE_EN
  logic unused_stride;
  assign unused_stride = ^stride;
  `endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    step_d   = step_q;
    remain_d = remain_q;
    issue    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_RUN;
            addr_d   = base_addr;
            remain_d = length;
            `ifdef READER_STRIDE_EN
            step_d   = stride;
            `else
            step_d   = ADDR_WIDTH'(1);
            `endif
          end
        end
      end
      ST_RUN: begin
        if (occupancy < OCC_W'(STREAM_BUF_DEPTH)) begin
          issue    = 1'b1;
          addr_d   = addr_q + step_q;
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the final word is accepted so done follows it by one cycle.
        if (!inflight_q && (buf_count == CNT_W'(pop))) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      step_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      step_q     <= step_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
    end
  end

  stream_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (STREAM_BUF_DEPTH)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (inflight_q),
    .push_dat_i (ram_dout),
    .pop_i      (pop),
    .count_o    (buf_count),
    .head_dat_o (m_if.m_data)
  );

endmodule

// File: tb/tb_tensor_ram_reader.sv
// Bench for tensor_ram_reader: RAM model plus a word-list reference built from base/length/step.
module tb_tensor_ram_reader;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic [AW-1:0] stride = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          busy, done;

  logic [DW-1:0] mem [8];
  logic [AW-1:0] exp_addr;
  int            total = 0;
  int            bad = 0;

  tensor_ram_reader_if #(.DATA_WIDTH(DW)) m_if ();

  tensor_ram_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .stride    (stride),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_if      (m_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[cyc % 6];
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_xfer(input logic [AW-1:0] b, input logic [LW-1:0] n,
                          input logic [AW-1:0] s, input int mode, input int abort_after);
    logic [DW-1:0] exp_q [$];
    int            step, cyc, pops, first_vld, last_pop, done_cyc;
    logic          prev_stall;
    logic [DW-1:0] prev_dat;
    `ifdef READER_STRIDE_EN
    step = int'(s);
    `else
    step = 1;
    `endif
    exp_q = {};
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(b) + i * step) % 8]);

    @(negedge clk);
    start = 1'b1; base_addr = b; length = n; stride = s; m_if.m_ready = rdy(mode, 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; pops = 0; first_vld = -1; last_pop = 0; done_cyc = -1; prev_stall = 1'b0; prev_dat = '0;
    check("addr_after_start", 32'(ram_addr), 32'((n != 0) ? b : exp_addr));
    if (n != 0) check("busy_run", 32'(busy), 32'd1);

    while (done_cyc < 0 && cyc < 400) begin
      m_if.m_ready = rdy(mode, cyc);
      #1;
      if (pops == abort_after) begin
        rst = 1'b1;
        #1;
        check("rst_vld", 32'(m_if.m_valid), 32'd0);
        check("rst_dat", m_if.m_data, 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_if.m_ready = 1'b0;
        exp_addr = '0;
        return;
      end
      if (prev_stall) begin
        check("stall_vld", 32'(m_if.m_valid), 32'd1);
        check("stall_dat", m_if.m_data, prev_dat);
      end
      if (m_if.m_valid && first_vld < 0) first_vld = cyc;
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) check("extra_word", 32'(pops + 1), 32'(n));
        else check("word", m_if.m_data, exp_q.pop_front());
        pops++;
        last_pop = cyc;
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_dat   = m_if.m_data;
      if (done) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end

    if (done_cyc < 0) begin
      check("timeout_done", 32'(done), 32'd1);
    end else begin
      check("done_cyc", 32'(done_cyc), 32'((n == 0) ? 1 : last_pop + 1));
      check("word_count", 32'(pops), 32'(n));
      if (n == 0) check("no_vld_len0", 32'(first_vld), 32'hFFFF_FFFF);
      if (mode == 0 && n != 0) check("first_vld", 32'(first_vld), 32'd3);
    end
    if (n != 0) exp_addr = AW'((int'(b) + int'(n) * step) % 8);
    @(negedge clk);
    m_if.m_ready = 1'b0;
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("vld_after", 32'(m_if.m_valid), 32'd0);
    check("addr_end", 32'(ram_addr), 32'(exp_addr));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 10);
    m_if.m_ready = 1'b0;
    rst = 1'b1;
    exp_addr = '0;
    #12;
    check("reset_addr", 32'(ram_addr), 32'd0);
    check("reset_vld", 32'(m_if.m_valid), 32'd0);
    check("reset_dat", m_if.m_data, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_xfer(3'd0, 4'd4, 3'd1, 0, -1);
    run_xfer(3'd6, 4'd4, 3'd1, 0, -1);
    run_xfer(3'd0, 4'd3, 3'd1, 1, -1);
    run_xfer(3'd5, 4'd0, 3'd1, 0, -1);
    run_xfer(3'd0, 4'd4, 3'd1, 0, 2);
    run_xfer(3'd0, 4'd2, 3'd1, 0, -1);
    `ifdef READER_STRIDE_EN
    run_xfer(3'd1, 4'd3, 3'd3, 0, -1);
    run_xfer(3'd2, 4'd2, 3'd0, 1, -1);
    `endif

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      run_xfer(AW'($urandom_range(0, 7)), LW'($urandom_range(0, 15)),
               AW'($urandom_range(0, 7)), int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
